// File: rtl/registro_instrucciones_fifo_pkg.sv
// Shared types and default configuration for the instruction register.
// Optional escape/extension-word decoding is enabled by REG_INSTR_EXT_IMM_EN.
package registro_pkg;

  localparam int INSTR_W_DEF = 9;
  localparam int OPC_W_DEF   = 3;
  localparam int OPND_W_DEF  = INSTR_W_DEF - OPC_W_DEF;
  localparam int IMM_W_DEF   = 8;
  localparam int DEPTH_DEF   = 2;

  // Bit k set: opcode k uses immediate addressing (default marks 000 and 010).
  localparam logic [2**OPC_W_DEF-1:0] IMM_OPC_MASK_DEF = 8'b0000_0101;

  typedef logic [OPC_W_DEF-1:0] opcode_t;

  typedef enum logic {
    DEC_IDLE     = 1'b0,
    DEC_WAIT_EXT = 1'b1
  } dec_state_e;

  typedef struct packed {
    opcode_t                opc;
    logic [OPND_W_DEF-1:0]  operands;
    logic [IMM_W_DEF-1:0]   imm;
  } dec_instr_t;

endpackage

// File: rtl/registro_instrucciones_fifo_if.sv
// Fetch-side and control-unit-side handshake bundle of the instruction register.
// slave is the register itself, master is whoever drives fetch words and consumes decodes.
interface registro_instrucciones_fifo_if
  import registro_pkg::*;
#(
  parameter int INSTR_W = INSTR_W_DEF,
  parameter int OPC_W   = OPC_W_DEF,
  parameter int IMM_W   = IMM_W_DEF,
  parameter int DEPTH   = DEPTH_DEF
);
  localparam int OPND_W = INSTR_W - OPC_W;
  localparam int CNT_W  = $clog2(DEPTH) + 1;

  logic               i_Flush;
  logic               i_Instr_valid;
  logic [INSTR_W-1:0] i_Instrucciones;
  logic               o_Instr_ready;
  logic               o_Dec_valid;
  logic               i_Dec_ready;
  logic [OPC_W-1:0]   o_Instruccion;
  logic [OPND_W-1:0]  o_Operandos;
  logic [IMM_W-1:0]   o_Direccionamiento_inmediato;
  logic [CNT_W-1:0]   o_Count;

  modport master (
    output i_Flush, i_Instr_valid, i_Instrucciones, i_Dec_ready,
    input  o_Instr_ready, o_Dec_valid, o_Instruccion, o_Operandos,
           o_Direccionamiento_inmediato, o_Count
  );

  modport slave (
    input  i_Flush, i_Instr_valid, i_Instrucciones, i_Dec_ready,
    output o_Instr_ready, o_Dec_valid, o_Instruccion, o_Operandos,
           o_Direccionamiento_inmediato, o_Count
  );

endinterface

// File: rtl/registro_instrucciones_fifo_fifo_sync.sv
// Power-of-two synchronous FIFO with occupancy count, synchronous reset and flush.
// The caller must not push when full nor pop when empty.
module fifo_sync #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic [CW-1:0]    count_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: storage is not reset; the pointers and count alone decide which entries are valid.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/registro_instrucciones_fifo.sv
// Instruction register: prefetch FIFO, field decode and registered valid/ready output stage.
// Defining REG_INSTR_EXT_IMM_EN turns an all-ones immediate into an escape for an extension word.
module registro_instrucciones_fifo
  import registro_pkg::*;
#(
  parameter int INSTR_W = INSTR_W_DEF,
  parameter int OPC_W   = OPC_W_DEF,
  parameter int IMM_W   = IMM_W_DEF,
  parameter int DEPTH   = DEPTH_DEF,
  parameter logic [2**OPC_W-1:0] IMM_OPC_MASK = IMM_OPC_MASK_DEF
) (
  input  logic                         i_Timming,
  input  logic                         i_Rst,
  registro_instrucciones_fifo_if.slave bus
);

  localparam int OPND_W = INSTR_W - OPC_W;
  localparam int HALF_W = OPND_W / 2;
  localparam int CNT_W  = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [OPC_W-1:0]  opc;
    logic [OPND_W-1:0] operands;
    logic [IMM_W-1:0]  imm;
  } dec_t;

  function automatic dec_t decode(input logic [INSTR_W-1:0] w);
    dec_t d;
    d.opc = w[INSTR_W-1 -: OPC_W];
    if (IMM_OPC_MASK[d.opc]) begin
      d.operands = {w[OPND_W-1:HALF_W], {HALF_W{1'b0}}};
      d.imm      = IMM_W'(w[HALF_W-1:0]);
    end else begin
      d.operands = w[OPND_W-1:0];
      d.imm      = '0;
    end
    return d;
  endfunction

  logic               push, pop, fifo_full, fifo_empty, clear;
  logic [INSTR_W-1:0] head;
  logic [CNT_W-1:0]   count;
  dec_t               head_dec, stage_q, stage_d;
  logic               valid_q, valid_d;
  dec_state_e         state_q, state_d;

  assign clear = i_Rst || bus.i_Flush;
  assign push  = bus.i_Instr_valid && bus.o_Instr_ready;
  assign pop   = !fifo_empty && (!valid_q || bus.i_Dec_ready);

  fifo_sync #(.WIDTH(INSTR_W), .DEPTH(DEPTH)) u_fifo (
    .clk     (i_Timming),
    .rst     (i_Rst),
    .flush_i (bus.i_Flush),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (bus.i_Instrucciones),
    .rdata_o (head),
    .count_o (count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign head_dec = decode(head);

`ifdef REG_INSTR_EXT_IMM_EN
  logic              escape;
  logic [OPC_W-1:0]  hold_opc_q;
  logic [OPND_W-1:0] hold_ops_q;

  assign escape = IMM_OPC_MASK[head_dec.opc] && (&head[HALF_W-1:0]);

  always_ff @(posedge i_Timming) begin
    if (clear) begin
      hold_opc_q <= '0;
      hold_ops_q <= '0;
    end else if (state_q == DEC_IDLE && pop && escape) begin
      hold_opc_q <= head_dec.opc;
      hold_ops_q <= head_dec.operands;
    end
  end
`endif

  always_ff @(posedge i_Timming) begin
    if (clear) state_q <= DEC_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    // NOTE: defaulting every combinational output first keeps synthesis from inferring latches.
    state_d = state_q;
`ifdef REG_INSTR_EXT_IMM_EN
    case (state_q)
      DEC_IDLE:     if (pop && escape) state_d = DEC_WAIT_EXT;
      DEC_WAIT_EXT: if (pop)           state_d = DEC_IDLE;
      default:                         state_d = DEC_IDLE;
    endcase
`endif
  end

  always_comb begin
    stage_d = stage_q;
    valid_d = valid_q;
    if (pop) begin
`ifdef REG_INSTR_EXT_IMM_EN
      if (state_q == DEC_WAIT_EXT) begin
        stage_d.opc      = hold_opc_q;
        stage_d.operands = hold_ops_q;
        stage_d.imm      = head[IMM_W-1:0];
        valid_d          = 1'b1;
      end else if (escape) begin
        valid_d = 1'b0;  // the extension word completes this instruction
      end else begin
        stage_d = head_dec;
        valid_d = 1'b1;
      end
`else
      stage_d = head_dec;
      valid_d = 1'b1;
`endif
    end else if (bus.i_Dec_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge i_Timming) begin
    if (clear) begin
      stage_q <= '0;
      valid_q <= 1'b0;
    end else begin
      stage_q <= stage_d;
      valid_q <= valid_d;
    end
  end

  assign bus.o_Instr_ready                = !fifo_full;
  assign bus.o_Dec_valid                  = valid_q;
  assign bus.o_Instruccion                = stage_q.opc;
  assign bus.o_Operandos                  = stage_q.operands;
  assign bus.o_Direccionamiento_inmediato = stage_q.imm;
  assign bus.o_Count                      = count;

endmodule

// File: tb/tb_registro_instrucciones_fifo.sv
// Directed bench for registro_instrucciones_fifo with hand-computed decode values.
// Expectations for the escape sequence follow REG_INSTR_EXT_IMM_EN.
module tb_registro_instrucciones_fifo;
  import registro_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  registro_instrucciones_fifo_if bus ();

  registro_instrucciones_fifo dut (
    .i_Timming (clk),
    .i_Rst     (rst),
    .bus       (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic dec_instr_t mk(input logic [2:0] opc, input logic [5:0] ops, input logic [7:0] imm);
    dec_instr_t d;
    d.opc      = opc;
    d.operands = ops;
    d.imm      = imm;
    return d;
  endfunction

  task automatic check_dec(input string tag, input dec_instr_t e);
    check({tag, ".valid"}, 32'(bus.o_Dec_valid), 32'd1);
    check({tag, ".opc"},   32'(bus.o_Instruccion), 32'(e.opc));
    check({tag, ".ops"},   32'(bus.o_Operandos), 32'(e.operands));
    check({tag, ".imm"},   32'(bus.o_Direccionamiento_inmediato), 32'(e.imm));
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".valid"}, 32'(bus.o_Dec_valid), 32'd0);
    check({tag, ".opc"},   32'(bus.o_Instruccion), 32'd0);
    check({tag, ".ops"},   32'(bus.o_Operandos), 32'd0);
    check({tag, ".imm"},   32'(bus.o_Direccionamiento_inmediato), 32'd0);
    check({tag, ".count"}, 32'(bus.o_Count), 32'd0);
    check({tag, ".ready"}, 32'(bus.o_Instr_ready), 32'd1);
  endtask

  // Advance one rising edge and return on the following falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [8:0] bp_words [4];
  dec_instr_t bp_dec   [3];

  initial begin
    bp_words[0] = 9'b011_010_110;  bp_dec[0] = mk(3'd3, 6'b010110, 8'd0);
    bp_words[1] = 9'b000_111_001;  bp_dec[1] = mk(3'd0, 6'b111000, 8'd1);
    bp_words[2] = 9'b101_001_100;  bp_dec[2] = mk(3'd5, 6'b001100, 8'd0);
    bp_words[3] = 9'b110_000_001;

    rst                 = 1'b1;
    bus.i_Flush         = 1'b0;
    bus.i_Instr_valid   = 1'b0;
    bus.i_Instrucciones = '0;
    bus.i_Dec_ready     = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check_zero("reset");

    // Single immediate word: visible after the second edge.
    bus.i_Instr_valid = 1'b1; bus.i_Instrucciones = 9'b000_101_011;
    tick();
    bus.i_Instr_valid = 1'b0;
    check("lat1.valid", 32'(bus.o_Dec_valid), 32'd0);
    check("lat1.count", 32'(bus.o_Count), 32'd1);
    tick();
    check_dec("imm_word", mk(3'd0, 6'b101000, 8'd3));
    check("imm_word.count", 32'(bus.o_Count), 32'd0);

    // Non-immediate word.
    bus.i_Instr_valid = 1'b1; bus.i_Instrucciones = 9'b001_110_010;
    tick();
    bus.i_Instr_valid = 1'b0;
    check("drain1.valid", 32'(bus.o_Dec_valid), 32'd0);
    tick();
    check_dec("reg_word", mk(3'd1, 6'b110010, 8'd0));
    tick();
    check("drain2.valid", 32'(bus.o_Dec_valid), 32'd0);

    // Backpressure: four back-to-back offers, three accepted.
    bus.i_Dec_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.i_Instr_valid   = 1'b1;
      bus.i_Instrucciones = bp_words[i];
      check($sformatf("bp.ready%0d", i), 32'(bus.o_Instr_ready), (i < 3) ? 32'd1 : 32'd0);
      tick();
    end
    bus.i_Instr_valid = 1'b0;
    check("bp.count", 32'(bus.o_Count), 32'd2);
    check("bp.ready", 32'(bus.o_Instr_ready), 32'd0);
    check_dec("bp.hold0", bp_dec[0]);
    tick();
    check_dec("bp.hold1", bp_dec[0]);
    check("bp.count_hold", 32'(bus.o_Count), 32'd2);
    bus.i_Dec_ready = 1'b1;
    tick();
    check_dec("bp.out1", bp_dec[1]);
    check("bp.count1", 32'(bus.o_Count), 32'd1);
    tick();
    check_dec("bp.out2", bp_dec[2]);
    check("bp.count2", 32'(bus.o_Count), 32'd0);
    tick();
    check("bp.empty.valid", 32'(bus.o_Dec_valid), 32'd0);

    // Flush with the FIFO full and valid held high.
    bus.i_Dec_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.i_Instr_valid   = 1'b1;
      bus.i_Instrucciones = bp_words[i];
      tick();
    end
    check("fl.pre_count", 32'(bus.o_Count), 32'd2);
    bus.i_Instrucciones = bp_words[3];
    bus.i_Flush         = 1'b1;
    tick();
    bus.i_Flush       = 1'b0;
    bus.i_Instr_valid = 1'b0;
    check_zero("flush_full");
    // Flush while a push is accepted: that word must vanish.
    bus.i_Dec_ready     = 1'b1;
    bus.i_Instr_valid   = 1'b1;
    bus.i_Instrucciones = 9'b001_110_010;
    bus.i_Flush         = 1'b1;
    tick();
    bus.i_Flush       = 1'b0;
    bus.i_Instr_valid = 1'b0;
    tick();
    check_zero("flush_push_dropped");

    // Reset mid-stream with valid asserted.
    bus.i_Instr_valid   = 1'b1;
    bus.i_Instrucciones = 9'b000_101_011;
    tick();
    tick();
    check("rst.pre_valid", 32'(bus.o_Dec_valid), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_zero("mid_reset");
    bus.i_Instrucciones = 9'b010_110_100;
    tick();
    bus.i_Instr_valid = 1'b0;
    check("post_rst.count", 32'(bus.o_Count), 32'd1);
    tick();
    check_dec("post_rst", mk(3'd2, 6'b110000, 8'd4));

    // Escape immediate followed by 9'h0A5.
    bus.i_Instr_valid   = 1'b1;
    bus.i_Instrucciones = 9'b010_001_111;
    tick();
    bus.i_Instrucciones = 9'h0A5;
    tick();
    bus.i_Instr_valid = 1'b0;
`ifdef REG_INSTR_EXT_IMM_EN
    check("esc.wait.valid", 32'(bus.o_Dec_valid), 32'd0);
    tick();
    check_dec("esc.ext", mk(3'd2, 6'b001000, 8'hA5));
    tick();
    check("esc.single.valid", 32'(bus.o_Dec_valid), 32'd0);
`else
    check_dec("esc.plain", mk(3'd2, 6'b001000, 8'd7));
    tick();
    check_dec("esc.second", mk(3'd2, 6'b100000, 8'd5));
    tick();
    check("esc.done.valid", 32'(bus.o_Dec_valid), 32'd0);
`endif
    check("esc.count", 32'(bus.o_Count), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/registro_instrucciones_fifo.md
Name: registro_instrucciones_fifo

Overview:
- Parametrised instruction register for the next generation of the UAZ microcontroller datapath.
- Accepts instruction words from the instruction-memory bus through a valid/ready handshake and buffers them in a small prefetch FIFO.
- Decodes each word into opcode, operands and immediate fields, then presents them to the control unit through a registered valid/ready output stage.
- Supports pipeline flush for branches and a configurable set of immediate-addressing opcodes.

Parameters:
- INSTR_W, 9: instruction word width.
- OPC_W, 3: opcode width, taken from the top bits of the word. Operand width OPND_W = INSTR_W-OPC_W (must be even).
- IMM_W, 8: immediate output width; must be ≥ OPND_W/2 and ≤ INSTR_W.
- DEPTH, 2: prefetch FIFO depth, power of two, ≥ 2.
- IMM_OPC_MASK, 8'b0000_0101: bit k set means opcode k uses immediate addressing. Width is 2**OPC_W; default marks opcodes 000 and 010.

Ports:
- i_Timming, input, 1: clock; all state updates on its rising edge.
- i_Rst, input, 1: reset.
- i_Flush, input, 1: synchronous flush (branch taken).
- i_Instr_valid, input, 1: fetch word valid.
- i_Instrucciones, input, INSTR_W: fetch word.
- o_Instr_ready, output, 1: FIFO can accept a word.
- o_Dec_valid, output, 1: decode outputs valid.
- i_Dec_ready, input, 1: control unit consumes the decode outputs.
- o_Instruccion, output, OPC_W: opcode.
- o_Operandos, output, OPND_W: operand field.
- o_Direccionamiento_inmediato, output, IMM_W: immediate value.
- o_Count, output, $clog2(DEPTH)+1: current FIFO occupancy.

Behaviour:
- Clock and reset: single clock i_Timming. i_Rst is synchronous and active-high.
- Reset: clears the FIFO pointers and count, o_Dec_valid, o_Instruccion, o_Operandos, o_Direccionamiento_inmediato, o_Count and the decode FSM (to DEC_IDLE). o_Instr_ready = 1 from the first cycle after reset. Reset mid-transfer discards all buffered words.
- Priority: i_Rst > i_Flush > normal operation.
- Flush: same clearing as reset. Any push in the flush cycle is dropped.
- Push: occurs when i_Instr_valid && o_Instr_ready. o_Instr_ready = (count < DEPTH) and does not look at the same-cycle pop. When full, push and pop never coincide.
- Pointers: wrap modulo DEPTH. Count +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
- Output stage load: loads from the FIFO head (pop) when the FIFO is non-empty and (!o_Dec_valid || i_Dec_ready).
  - If the stage empties and nothing loads, o_Dec_valid falls.
  - While o_Dec_valid && !i_Dec_ready, all decode outputs are held stable.
- Latency and throughput: a word pushed at edge N appears on the outputs with o_Dec_valid = 1 after edge N+1, provided the stage is free. Throughput is 1 word/cycle with i_Dec_ready held high. Up to DEPTH+1 words are in flight (FIFO plus output stage).
- Decode, immediate opcode (IMM_OPC_MASK[opc] = 1):
  - o_Operandos = {word[OPND_W-1:OPND_W/2], zeros}.
  - o_Direccionamiento_inmediato = zero-extended word[OPND_W/2-1:0].
- Decode, other opcodes:
  - o_Operandos = word[OPND_W-1:0].
  - o_Direccionamiento_inmediato = 0.
- Decode FSM without the optional feature: DEC_IDLE only.

Optional Feature:
- Macro: REG_INSTR_EXT_IMM_EN.
- When defined:
  - An immediate opcode whose low field is all ones (escape) is followed by an extension word.
  - On popping the escape word, the FSM moves DEC_IDLE → DEC_WAIT_EXT and stores the opcode and operands in a holding register. o_Dec_valid does not rise.
  - In DEC_WAIT_EXT, the next FIFO word is popped as soon as available. The output loads holding opcode/operands, with o_Direccionamiento_inmediato = ext[IMM_W-1:0]. o_Dec_valid rises and the FSM returns to DEC_IDLE.
  - Flush or reset in DEC_WAIT_EXT returns to DEC_IDLE and discards the held word.
- When undefined: an escape value decodes as an ordinary immediate (all ones, zero-extended).

Decomposition:
- Shared package registro_pkg:
  - opcode typedef, OPC_W/INSTR_W constants.
  - default IMM_OPC_MASK, decode FSM state enum.
  - decoded-instruction struct {opc, operands, imm}.
- Sub-module fifo_sync: parametrised width/depth FIFO with push/pop/count, synchronous reset and flush, instantiated once.

Test Plan:
- Push 9'b000_101_011 with ready high → after 2 edges, o_Dec_valid = 1, o_Instruccion = 000, o_Operandos = 6'b101000, o_Direccionamiento_inmediato = 8'd3.
- Push 9'b001_110_010 → opcode 001, operands 6'b110010, imm 8'd0.
- Hold i_Dec_ready = 0 and push 4 words back to back → 3 accepted, o_Instr_ready = 0 and o_Count = 2, outputs stable. Raise i_Dec_ready → words emerge in order, one per cycle.
- With the FIFO full and valid high, assert i_Flush for one cycle → o_Dec_valid = 0, o_Count = 0, o_Instr_ready = 1. The flush-cycle push is dropped.
- Assert i_Rst mid-stream with i_Instr_valid = 1 → every output is 0 the next cycle, and the first post-reset word decodes correctly.
- With REG_INSTR_EXT_IMM_EN, push 9'b010_001_111 then 9'h0A5 → a single decode with opcode 010, operands 6'b001000, imm 8'hA5. Without the macro, the same words give imm 8'd7 followed by a second decode of 9'h0A5.
